atable_fetch_ctrl: RTL and testbench

- Sequences reads from the attribute-table ROM (128×8, registered output, 2 nametables × 64 bytes) for the tile renderer.
- On a per-row load request, issues the 8 byte reads for the current attribute row and extracts the 16 two-bit palette selects for that tile row into a back buffer.
- Swaps the back buffer to the front on request; the renderer looks up the front buffer by tile column during active video.

---
 rtl/atable_fetch_if.sv | 24 ++
 rtl/atable_fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_atable_fetch_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/atable_fetch_if.sv
// Renderer-side and ROM-side signals of the attribute-table fetch controller.
interface atable_fetch_if;
  logic       load;
  logic       nt_sel;
  logic [4:0] tile_row;
  logic       swap;
  logic [4:0] tile_col;
  logic [6:0] rom_addr;
  logic [7:0] rom_dout;
  logic [1:0] pal_sel;
  logic       busy;
  logic       done;
  logic       ovr;

  modport slave (
    input  load, nt_sel, tile_row, swap, tile_col, rom_dout,
    output rom_addr, pal_sel, busy, done, ovr
  );

  modport master (
    output load, nt_sel, tile_row, swap, tile_col, rom_dout,
    input  rom_addr, pal_sel, busy, done, ovr
  );
endinterface

// File: rtl/atable_fetch_ctrl.sv
// Attribute-table fetch controller: reads one 8-byte attribute row from ROM,
// unpacks 16 palette selects into a back buffer, serves lookups from a front buffer.
module atable_fetch_ctrl #(
  parameter int RD_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  atable_fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            w_accept;
  logic            w_reject;
  logic            w_issue;
  logic            w_cap;
  logic            w_last_cap;
  logic [2:0]      w_iss_k_nxt;

  logic            r_nt_q;
  logic [3:0]      r_row_q;
  logic [2:0]      r_iss_k;
  logic [2:0]      r_cap_k;
  logic [RD_LAT:0] r_cap_vld_p;
  logic            r_back_valid;
  logic [1:0]      r_back  [16];
  logic [1:0]      r_front [16];
  logic [6:0]      r_rom_addr;
  logic [1:0]      r_pal_sel;
  logic            r_busy;
  logic            r_done;
  logic            r_ovr;

  // 2-bit quadrant field: h picks the nibble (top/bottom tile half), q the pair.
  function automatic logic [1:0] extract_sel(input logic [7:0] b, input logic h,
                                             input logic q);
    logic [2:0] off;
    off = {h, q, 1'b0};
    return b[off +: 2];
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_issue     = 1'b0;
    w_iss_k_nxt = r_iss_k + 3'd1;
    w_cap       = r_cap_vld_p[RD_LAT];
    w_last_cap  = w_cap && (r_cap_k == 3'd7);
    case (r_state)
      IDLE: begin
        if (bus.load) begin
          w_accept    = 1'b1;
          w_issue     = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        w_reject = bus.load;
        w_issue  = 1'b1;
        if (w_iss_k_nxt == 3'd7) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_reject = bus.load;
        if (w_last_cap) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Issue side; capture validity trails each issue by the ROM pipe plus one register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nt_q       <= 1'b0;
      r_row_q      <= '0;
      r_iss_k      <= '0;
      r_cap_k      <= '0;
      r_cap_vld_p  <= '0;
      r_back_valid <= 1'b0;
      r_rom_addr   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ovr        <= 1'b0;
    end else begin
      r_cap_vld_p <= {r_cap_vld_p[RD_LAT-1:0], w_issue};
      r_done      <= w_last_cap;
      r_ovr       <= w_reject;
      if (w_accept) begin
        r_nt_q       <= bus.nt_sel;
        r_row_q      <= bus.tile_row[4:1];
        r_iss_k      <= 3'd0;
        r_cap_k      <= 3'd0;
        r_rom_addr   <= {bus.nt_sel, bus.tile_row[4:2], 3'd0};
        r_busy       <= 1'b1;
        r_back_valid <= 1'b0;
      end else if (r_state == FETCH) begin
        r_iss_k    <= w_iss_k_nxt;
        r_rom_addr <= {r_nt_q, r_row_q[3:1], w_iss_k_nxt};
      end
      if (w_cap) r_cap_k <= r_cap_k + 3'd1;
      if (w_last_cap) begin
        r_busy       <= 1'b0;
        r_back_valid <= 1'b1;
      end
    end
  end

  // Capture, swap and lookup; lookup on a swap edge still sees the old front.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_back[i]  <= '0;
        r_front[i] <= '0;
      end
      r_pal_sel <= '0;
    end else begin
      if (w_cap) begin
        r_back[{r_cap_k, 1'b0}] <= extract_sel(bus.rom_dout, r_row_q[0], 1'b0);
        r_back[{r_cap_k, 1'b1}] <= extract_sel(bus.rom_dout, r_row_q[0], 1'b1);
      end
      if (bus.swap && r_back_valid) begin
        for (int i = 0; i < 16; i++) r_front[i] <= r_back[i];
      end
      r_pal_sel <= r_front[bus.tile_col[4:1]];
    end
  end

  assign bus.rom_addr = r_rom_addr;
  assign bus.pal_sel  = r_pal_sel;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.ovr      = r_ovr;
endmodule

// File: tb/tb_atable_fetch_ctrl.sv
// Directed bench for atable_fetch_ctrl: RD_LAT=1 and RD_LAT=2 instances share stimulus.
module tb_atable_fetch_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       nt_sel = 1'b0;
  logic       swap = 1'b0;
  logic [4:0] tile_row = '0;
  logic [4:0] tile_col = '0;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] exp_pal [32];

  logic [7:0] rom [128];
  logic [7:0] r1_q;
  logic [7:0] r2_a;
  logic [7:0] r2_b;

  always #5 clk = ~clk;

  atable_fetch_if if1 ();
  atable_fetch_if if2 ();

  assign if1.load = load;     assign if2.load = load;
  assign if1.nt_sel = nt_sel; assign if2.nt_sel = nt_sel;
  assign if1.tile_row = tile_row; assign if2.tile_row = tile_row;
  assign if1.swap = swap;     assign if2.swap = swap;
  assign if1.tile_col = tile_col; assign if2.tile_col = tile_col;

  // Registered ROM models: one and two cycles of read latency.
  always @(posedge clk) begin
    r1_q <= rom[if1.rom_addr];
    r2_a <= rom[if2.rom_addr];
    r2_b <= r2_a;
  end
  assign if1.rom_dout = r1_q;
  assign if2.rom_dout = r2_b;

  atable_fetch_ctrl #(.RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  atable_fetch_ctrl #(.RD_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic check_lookup(input string tag);
    for (int c = 0; c < 32; c++) begin
      tile_col = 5'(c);
      tick();
      check_val($sformatf("%s lat1 pal c%0d", tag, c), int'(if1.pal_sel), int'(exp_pal[c]));
      check_val($sformatf("%s lat2 pal c%0d", tag, c), int'(if2.pal_sel), int'(exp_pal[c]));
    end
  endtask

  task automatic fill_exp(input logic [1:0] v);
    for (int c = 0; c < 32; c++) exp_pal[c] = v;
  endtask

  // Load at E0, optional second load at E(ovr_at) and swap at E(swap_at).
  task automatic run_fetch(input logic nt, input logic [4:0] row, input int ovr_at,
                           input int swap_at, input string tag);
    int b1, b2, d1, d2, d1at, d2at, o1, o2, exp_a;
    logic [6:0] base;
    base = {nt, row[4:2], 3'd0};
    nt_sel = nt;
    tile_row = row;
    load = 1'b1;
    swap = (swap_at == 0);
    tick();
    load = 1'b0;
    swap = 1'b0;
    check_val({tag, " addr0 lat1"}, int'(if1.rom_addr), int'(base));
    check_val({tag, " addr0 lat2"}, int'(if2.rom_addr), int'(base));
    b1 = int'(if1.busy); b2 = int'(if2.busy);
    d1 = 0; d2 = 0; d1at = -1; d2at = -1; o1 = 0; o2 = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == ovr_at) begin
        load = 1'b1;
        nt_sel = ~nt;
        tile_row = ~row;
      end
      swap = (i == swap_at);
      tick();
      load = 1'b0;
      swap = 1'b0;
      nt_sel = nt;
      tile_row = row;
      exp_a = int'(base) + ((i < 7) ? i : 7);
      check_val($sformatf("%s addr%0d lat1", tag, i), int'(if1.rom_addr), exp_a);
      check_val($sformatf("%s addr%0d lat2", tag, i), int'(if2.rom_addr), exp_a);
      b1 += int'(if1.busy);
      b2 += int'(if2.busy);
      o1 += int'(if1.ovr);
      o2 += int'(if2.ovr);
      if (if1.done) begin d1++; d1at = i; end
      if (if2.done) begin d2++; d2at = i; end
    end
    check_val({tag, " busy cycles lat1"}, b1, 9);
    check_val({tag, " busy cycles lat2"}, b2, 10);
    check_val({tag, " done count lat1"}, d1, 1);
    check_val({tag, " done count lat2"}, d2, 1);
    check_val({tag, " done cycle lat1"}, d1at, 9);
    check_val({tag, " done cycle lat2"}, d2at, 10);
    check_val({tag, " ovr count lat1"}, o1, (ovr_at > 0) ? 1 : 0);
    check_val({tag, " ovr count lat2"}, o2, (ovr_at > 0) ? 1 : 0);
  endtask

  initial begin
    int dn;
    for (int i = 0; i < 128; i++) rom[i] = 8'h55;
    rom[0] = 8'hAA; rom[1] = 8'hAA; rom[2] = 8'hEA; rom[3] = 8'hAA;
    rom[4] = 8'hAA; rom[5] = 8'hAA; rom[6] = 8'hAA; rom[7] = 8'hAA;
    rom[8'h48] = 8'h00;
    rom[8'h49] = 8'h88;

    rst = 1'b1;
    tick();
    tick();
    check_val("reset rom_addr", int'(if1.rom_addr), 0);
    check_val("reset pal_sel", int'(if1.pal_sel), 0);
    check_val("reset busy", int'(if1.busy), 0);
    check_val("reset done", int'(if1.done), 0);
    check_val("reset ovr", int'(if1.ovr), 0);
    check_val("reset busy lat2", int'(if2.busy), 0);
    rst = 1'b0;

    // Row 0, top half: every quadrant of AA/EA low nibble is 2.
    run_fetch(1'b0, 5'd0, -1, -1, "s1");
    do_swap();
    fill_exp(2'd2);
    check_lookup("s1");

    // Row 2, bottom half: byte 2 = EA gives 2 then 3 for entries 4,5.
    run_fetch(1'b0, 5'd2, -1, -1, "s2");
    swap = 1'b1;
    tile_col = 5'd10;
    tick();
    swap = 1'b0;
    check_val("s2 lookup on swap edge", int'(if1.pal_sel), 2);
    tick();
    check_val("s2 lookup after swap", int'(if1.pal_sel), 3);
    fill_exp(2'd2);
    exp_pal[10] = 2'd3;
    exp_pal[11] = 2'd3;
    check_lookup("s2");

    // Nametable 1, row 4: addresses 0x48..0x4F.
    run_fetch(1'b1, 5'd4, -1, -1, "s3");
    do_swap();
    fill_exp(2'd1);
    for (int c = 0; c < 6; c++) exp_pal[c] = 2'd0;
    exp_pal[6] = 2'd2;
    exp_pal[7] = 2'd2;
    check_lookup("s3");

    // Rejected reload and swap while busy: front keeps the s3 contents.
    run_fetch(1'b0, 5'd0, 3, 5, "s4");
    check_lookup("s4");

    // Load and swap on one edge: swap takes the old back (all 2), then row 2 fetches.
    run_fetch(1'b0, 5'd2, -1, 0, "s5");
    fill_exp(2'd2);
    check_lookup("s5a");
    do_swap();
    exp_pal[10] = 2'd3;
    exp_pal[11] = 2'd3;
    check_lookup("s5b");

    // Reset in the middle of a fetch.
    nt_sel = 1'b0;
    tile_row = 5'd0;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_val("s6 busy after rst lat1", int'(if1.busy), 0);
    check_val("s6 busy after rst lat2", int'(if2.busy), 0);
    check_val("s6 pal_sel after rst", int'(if1.pal_sel), 0);
    check_val("s6 rom_addr after rst", int'(if1.rom_addr), 0);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      dn += int'(if1.done) + int'(if2.done);
    end
    check_val("s6 no done after abort", dn, 0);
    do_swap();
    fill_exp(2'd0);
    check_lookup("s6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
